// File: rtl/e_mdu_if.sv
// Bundle of the E-stage multiply/divide unit signals.
// The pipeline side drives operands and the op; the unit returns status and HI/LO.
interface e_mdu_if;
   logic [31:0] E_RD1;
   logic [31:0] E_RD2;
   logic [3:0]  E_mdu_op;
   logic        E_allow;
   logic [31:0] E_MDU_out;
   logic        E_busy;
   logic        E_mdu_stall;
   logic [31:0] E_HI;
   logic [31:0] E_LO;

   modport master (
      output E_RD1, E_RD2, E_mdu_op, E_allow,
      input  E_MDU_out, E_busy, E_mdu_stall, E_HI, E_LO
   );

   modport slave (
      input  E_RD1, E_RD2, E_mdu_op, E_allow,
      output E_MDU_out, E_busy, E_mdu_stall, E_HI, E_LO
   );
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Results are written only on the final busy edge, so HI/LO never show partial values.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic    clk,
   input  logic    reset,
   e_mdu_if.slave  bus
);
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [3:0]  op_reg, op_next;
   logic [31:0] a_reg, a_next;
   logic [31:0] b_reg, b_next;
   logic [31:0] hi_reg, hi_next;
   logic [31:0] lo_reg, lo_next;

   logic        is_start_op;
   logic        is_move_op;
   logic        start;

   // Operands are widened to 64 bits so that 0x80000000 / -1 yields 2^31,
   // whose low word is the required 0x80000000 quotient with zero remainder.
   logic signed [63:0] a_s, b_s, prod_s, quot_s, rem_s;
   logic        [63:0] a_u, b_u, prod_u;
   logic        [31:0] quot_u, rem_u;

   assign a_s    = {{32{a_reg[31]}}, a_reg};
   assign b_s    = {{32{b_reg[31]}}, b_reg};
   assign a_u    = {32'd0, a_reg};
   assign b_u    = {32'd0, b_reg};
   assign prod_s = a_s * b_s;
   assign prod_u = a_u * b_u;
   assign quot_s = a_s / b_s;
   assign rem_s  = a_s % b_s;
   assign quot_u = a_reg / b_reg;
   assign rem_u  = a_reg % b_reg;

   assign is_start_op = (bus.E_mdu_op >= OP_MULT) && (bus.E_mdu_op <= OP_DIVU);
   assign is_move_op  = (bus.E_mdu_op >= OP_MFHI) && (bus.E_mdu_op <= OP_MTLO);
   assign start       = (state_reg == IDLE) && bus.E_allow && is_start_op;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      op_next    = op_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = BUSY;
               a_next     = bus.E_RD1;
               b_next     = bus.E_RD2;
               op_next    = bus.E_mdu_op;
               cnt_next   = (bus.E_mdu_op <= OP_MULTU) ? MULT_CNT : DIV_CNT;
            end else if (bus.E_allow && bus.E_mdu_op == OP_MTHI) begin
               hi_next = bus.E_RD1;
            end else if (bus.E_allow && bus.E_mdu_op == OP_MTLO) begin
               lo_next = bus.E_RD1;
            end
         end
         BUSY: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
               state_next = IDLE;
               // A zero divisor still spends the full busy time but leaves HI/LO alone.
               case (op_reg)
                  OP_MULT:  {hi_next, lo_next} = prod_s;
                  OP_MULTU: {hi_next, lo_next} = prod_u;
                  OP_DIV: begin
                     if (b_reg != 32'd0) begin
                        hi_next = rem_s[31:0];
                        lo_next = quot_s[31:0];
                     end
                  end
                  OP_DIVU: begin
                     if (b_reg != 32'd0) begin
                        hi_next = rem_u;
                        lo_next = quot_u;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         op_reg    <= 4'd0;
         a_reg     <= 32'd0;
         b_reg     <= 32'd0;
         hi_reg    <= 32'd0;
         lo_reg    <= 32'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         op_reg    <= op_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
      end
   end

   assign bus.E_busy      = (state_reg == BUSY);
   assign bus.E_mdu_stall = bus.E_busy | start | (bus.E_allow & is_move_op & bus.E_busy);
   assign bus.E_HI        = hi_reg;
   assign bus.E_LO        = lo_reg;
   assign bus.E_MDU_out   = (bus.E_mdu_op == OP_MFHI) ? hi_reg :
                            (bus.E_mdu_op == OP_MFLO) ? lo_reg : 32'd0;
endmodule
